// File: rtl/mem_wb_pipe_if.sv
// mem_wb_pipe_if: ready-handshaked word memory port between the MEM stage (master) and data memory (slave)
interface mem_wb_pipe_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rdata);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: EX/MEM and MEM/WB registers with data-memory access, timeout watchdog and stall; MEM/WB outputs feed EX forwarding
module mem_wb_pipe #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_ex,
    input  logic [31:0]        ALUResult_ex,
    input  logic [31:0]        MemWriteData_ex,
    input  logic [4:0]         rdAddr_ex,
    input  logic               RegWrite_ex,
    input  logic               MemRead_ex,
    input  logic               MemWrite_ex,
    input  logic               MemtoReg_ex,
    mem_wb_pipe_if.master      bus,
    output logic [31:0]        ALUResult_mem,
    output logic [4:0]         rdAddr_mem,
    output logic               RegWrite_mem,
    output logic               load_mem,
    output logic [31:0]        RegWriteData_wb,
    output logic [4:0]         rdAddr_wb,
    output logic               RegWrite_wb,
    output logic               stall_mem,
    output logic               mem_error
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t           state, state_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic             valid_mem, rw_mem_r, mr_mem, mw_mem, m2r_mem;
    logic [31:0]      wdata_mem;
    logic             access, misaligned, ready_ok, timeout, done;
    assign access        = valid_mem & (mr_mem | mw_mem);
    assign misaligned    = access & (ALUResult_mem[1:0] != 2'b00);
    assign bus.mem_req   = access & ~misaligned;
    assign bus.mem_we    = mw_mem;
    assign bus.mem_addr  = ALUResult_mem;
    assign bus.mem_wdata = wdata_mem;
    assign ready_ok      = bus.mem_req & bus.mem_ready;
    assign timeout       = (state == WAIT) & (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) & ~bus.mem_ready;
    assign done          = ~access | misaligned | ready_ok | timeout;
    assign stall_mem     = ~done;
    assign RegWrite_mem  = valid_mem & rw_mem_r & (rdAddr_mem != 5'd0);
    assign load_mem      = valid_mem & mr_mem;
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        if (state == IDLE) begin
            if (bus.mem_req & ~bus.mem_ready) begin
                state_n    = WAIT;
                wait_cnt_n = CNT_W'(1);
            end
        end else if (ready_ok | timeout) begin
            state_n    = IDLE;
            wait_cnt_n = '0;
        end else begin
            wait_cnt_n = wait_cnt + CNT_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            valid_mem       <= 1'b0;
            ALUResult_mem   <= '0;
            wdata_mem       <= '0;
            rdAddr_mem      <= '0;
            rw_mem_r        <= 1'b0;
            mr_mem          <= 1'b0;
            mw_mem          <= 1'b0;
            m2r_mem         <= 1'b0;
            RegWriteData_wb <= '0;
            rdAddr_wb       <= '0;
            RegWrite_wb     <= 1'b0;
            mem_error       <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            mem_error <= mem_error | timeout | misaligned;
            if (!stall_mem) begin
                valid_mem     <= valid_ex;
                ALUResult_mem <= ALUResult_ex;
                wdata_mem     <= MemWriteData_ex;
                rdAddr_mem    <= rdAddr_ex;
                rw_mem_r      <= RegWrite_ex;
                mr_mem        <= MemRead_ex;
                mw_mem        <= MemWrite_ex;
                m2r_mem       <= MemtoReg_ex;
            end
            // a failed or timed-out load writes zero rather than stale bus data
            if (done & valid_mem) begin
                rdAddr_wb       <= rdAddr_mem;
                RegWrite_wb     <= RegWrite_mem;
                RegWriteData_wb <= m2r_mem ? (ready_ok ? bus.mem_rdata : 32'h0) : ALUResult_mem;
            end else begin
                RegWrite_wb <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: table-driven and sequence checks of mem_wb_pipe
module tb_mem_wb_pipe;
    localparam int MEM_TIMEOUT = 16;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex;
    logic [31:0] ALUResult_ex, MemWriteData_ex;
    logic [4:0]  rdAddr_ex;
    logic [31:0] ALUResult_mem, RegWriteData_wb;
    logic [4:0]  rdAddr_mem, rdAddr_wb;
    logic        RegWrite_mem, load_mem, RegWrite_wb, stall_mem, mem_error;
    int          checks = 0;
    int          errors = 0;
    mem_wb_pipe_if bus();
    mem_wb_pipe #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .ALUResult_ex(ALUResult_ex),
        .MemWriteData_ex(MemWriteData_ex), .rdAddr_ex(rdAddr_ex), .RegWrite_ex(RegWrite_ex),
        .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex),
        .bus(bus), .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem),
        .RegWrite_mem(RegWrite_mem), .load_mem(load_mem), .RegWriteData_wb(RegWriteData_wb),
        .rdAddr_wb(rdAddr_wb), .RegWrite_wb(RegWrite_wb), .stall_mem(stall_mem), .mem_error(mem_error)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu, wd;
        logic        rw, mr, mw, m2r, rdy;
        logic [31:0] rdata;
        logic        e_req, e_stall, e_ld, e_rwm, e_rwb;
        logic [31:0] e_wbd;
        logic        e_err;
    } vec_t;
    vec_t vecs[6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic set_ex(input logic v, input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        valid_ex = v; rdAddr_ex = rd; ALUResult_ex = alu; MemWriteData_ex = wd;
        RegWrite_ex = rw; MemRead_ex = mr; MemWrite_ex = mw; MemtoReg_ex = m2r;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int n;
        vecs[0] = '{5'd5,  32'h1234,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1234,     1'b0};
        vecs[1] = '{5'd7,  32'h40,       32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{5'd0,  32'h55,       32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55,       1'b0};
        vecs[3] = '{5'd0,  32'h10,       32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h77,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10,       1'b0};
        vecs[4] = '{5'd12, 32'hABC,      32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hABC,      1'b0};
        vecs[5] = '{5'd8,  32'h42,       32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1111,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1};
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst mem_req", 32'(bus.mem_req), 0);
        chk("rst stall", 32'(stall_mem), 0);
        chk("rst RegWrite_mem", 32'(RegWrite_mem), 0);
        chk("rst RegWrite_wb", 32'(RegWrite_wb), 0);
        chk("rst RegWriteData_wb", RegWriteData_wb, 0);
        chk("rst mem_error", 32'(mem_error), 0);
        reset = 1'b0;
        tick();
        // load that waits three cycles, with an ADD queued behind it in EX
        set_ex(1, 5'd9, 32'h80, 0, 1, 1, 0, 1);
        tick();
        set_ex(1, 5'd10, 32'h777, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wait stall %0d", i), 32'(stall_mem), 1);
            chk($sformatf("wait held rd %0d", i), 32'(rdAddr_mem), 9);
            chk($sformatf("wait wb bubble %0d", i), 32'(RegWrite_wb), 0);
            tick();
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5A5A5A5A;
        #1;
        chk("wait ready no stall", 32'(stall_mem), 0);
        tick();
        bus.mem_ready = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wait wb data", RegWriteData_wb, 32'h5A5A5A5A);
        chk("wait wb rd", 32'(rdAddr_wb), 9);
        chk("wait wb we", 32'(RegWrite_wb), 1);
        chk("queued add in mem", 32'(rdAddr_mem), 10);
        tick();
        chk("queued add wb", RegWriteData_wb, 32'h777);
        for (int i = 0; i < 6; i++) begin
            set_ex(1, vecs[i].rd, vecs[i].alu, vecs[i].wd, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].m2r);
            tick();
            set_ex(0, 0, 0, 0, 0, 0, 0, 0);
            bus.mem_ready = vecs[i].rdy;
            bus.mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d mem_req", i), 32'(bus.mem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d stall", i), 32'(stall_mem), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d load_mem", i), 32'(load_mem), 32'(vecs[i].e_ld));
            chk($sformatf("v%0d RegWrite_mem", i), 32'(RegWrite_mem), 32'(vecs[i].e_rwm));
            chk($sformatf("v%0d rdAddr_mem", i), 32'(rdAddr_mem), 32'(vecs[i].rd));
            chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].alu);
            if (vecs[i].mw) begin
                chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 1);
                chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].wd);
            end
            tick();
            bus.mem_ready = 1'b0;
            chk($sformatf("v%0d RegWrite_wb", i), 32'(RegWrite_wb), 32'(vecs[i].e_rwb));
            chk($sformatf("v%0d RegWriteData_wb", i), RegWriteData_wb, vecs[i].e_wbd);
            chk($sformatf("v%0d rdAddr_wb", i), 32'(rdAddr_wb), 32'(vecs[i].rd));
            chk($sformatf("v%0d mem_error", i), 32'(mem_error), 32'(vecs[i].e_err));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst clears error", 32'(mem_error), 0);
        // store with no response times out
        set_ex(1, 5'd0, 32'h10, 32'h1234, 0, 0, 1, 0);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (bus.mem_req === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("timeout req cycles", n, MEM_TIMEOUT);
        chk("timeout mem_error", 32'(mem_error), 1);
        chk("timeout resumes", 32'(stall_mem), 0);
        // reset while an access waits
        set_ex(1, 5'd4, 32'h20, 0, 1, 1, 0, 1);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("pre-reset stall", 32'(stall_mem), 1);
        reset = 1'b1;
        tick();
        chk("midrst mem_req", 32'(bus.mem_req), 0);
        chk("midrst stall", 32'(stall_mem), 0);
        chk("midrst RegWrite_mem", 32'(RegWrite_mem), 0);
        chk("midrst RegWrite_wb", 32'(RegWrite_wb), 0);
        chk("midrst mem_error", 32'(mem_error), 0);
        reset = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
